// File: rtl/conv_pkg_ys.sv
// Shared definitions for the streaming convolution engine: FSM encoding and
// width helpers derived from the block parameters.
package conv_pkg_ys;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadWt  = 3'd1,
    StLoadIfm = 3'd2,
    StDrain   = 3'd3,
    StDone    = 3'd4
  } conv_state_e;

  // Enough headroom to sum K*K full-width products without overflow.
  function automatic int unsigned acc_width(int unsigned dw, int unsigned k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Counters that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // Index into a memory of max_dim entries.
  function automatic int unsigned ptr_width(int unsigned max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer_ys.sv
// Line buffer and KxK window for the convolution engine. The window output is the
// window as it will be once the current pixel is shifted in, so the MAC can use it the same cycle.
module conv_line_buffer_ys
  import conv_pkg_ys::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned WT_DIM     = 3,
  parameter int unsigned MAX_FM_DIM = 64,
  localparam int unsigned CntW      = cnt_width(MAX_FM_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [CntW-1:0]   row_len,
  input  logic [DWIDTH-1:0] pix,
  output logic [DWIDTH-1:0] win [WT_DIM][WT_DIM]
);

  localparam int unsigned PtrW = ptr_width(MAX_FM_DIM);

  if (WT_DIM > 1) begin : g_lines
    logic [PtrW-1:0]   ptr_q;
    // line_q[k][c] holds column c of the row k+1 rows above the current one.
    logic [DWIDTH-1:0] line_q [WT_DIM-1][MAX_FM_DIM];
    // Rightmost K-1 columns of the previous window.
    logic [DWIDTH-1:0] hist_q [WT_DIM][WT_DIM-1];
    logic [DWIDTH-1:0] col    [WT_DIM];

    always_comb begin
      for (int i = 0; i < WT_DIM - 1; i++) col[i] = line_q[WT_DIM-2-i][ptr_q];
      col[WT_DIM-1] = pix;
      for (int i = 0; i < WT_DIM; i++) begin
        for (int j = 0; j < WT_DIM - 1; j++) win[i][j] = hist_q[i][j];
        win[i][WT_DIM-1] = col[i];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ptr_q <= '0;
      end else if (clear) begin
        ptr_q <= '0;
      end else if (shift) begin
        if (CntW'(ptr_q) == row_len - CntW'(1)) ptr_q <= '0;
        else                                     ptr_q <= ptr_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (shift) begin
        line_q[0][ptr_q] <= pix;
        for (int k = 1; k < WT_DIM - 1; k++) line_q[k][ptr_q] <= line_q[k-1][ptr_q];
        for (int i = 0; i < WT_DIM; i++) begin
          for (int j = 0; j < WT_DIM - 1; j++) hist_q[i][j] <= win[i][j+1];
        end
      end
    end
  end else begin : g_single
    always_comb win[0][0] = pix;
  end

endmodule

// File: rtl/conv_compute_ys.sv
// Streaming valid-mode 2D convolution: loads a KxK kernel, streams an NxN map, emits
// (N-K+1)^2 outputs. Define CONV_RELU_EN to clamp negative results to zero.
module conv_compute_ys
  import conv_pkg_ys::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned WT_DIM     = 3,
  parameter int unsigned MAX_FM_DIM = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       fm_dim,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] wt_addr,
  input  logic [DWIDTH-1:0] wt_dout,
  input  logic              wt_dout_valid,
  output logic              wt_dout_ready,
  output logic [AWIDTH-1:0] ifm_addr,
  input  logic [DWIDTH-1:0] ifm_dout,
  input  logic              ifm_dout_valid,
  output logic              ifm_dout_ready,
  output logic [AWIDTH-1:0] ofm_addr,
  output logic [DWIDTH-1:0] ofm_din,
  output logic              ofm_din_valid,
  input  logic              ofm_din_ready
);

  localparam int          KK     = WT_DIM * WT_DIM;
  localparam int unsigned AccW   = acc_width(DWIDTH, WT_DIM);
  localparam int unsigned CntW   = cnt_width(MAX_FM_DIM);
  localparam int unsigned WtCntW = cnt_width(KK);

  conv_state_e          state;
  logic [CntW-1:0]      n_q, row_q, col_q;
  logic [WtCntW-1:0]    wt_cnt_q;
  logic [DWIDTH-1:0]    wt_q [KK];
  logic [DWIDTH-1:0]    win  [WT_DIM][WT_DIM];
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [AccW-1:0]     acc;
  logic [DWIDTH-1:0]    result;
  logic wt_fire, ifm_fire, ofm_fire, win_full, col_last, last_px, wt_last;

  assign wt_addr        = '0;
  assign ifm_addr       = '0;
  assign wt_fire        = wt_dout_valid && wt_dout_ready;
  assign ifm_fire       = ifm_dout_valid && ifm_dout_ready;
  assign ofm_fire       = ofm_din_valid && ofm_din_ready;
  // The single output slot may be refilled in the same cycle it drains.
  assign ifm_dout_ready = (state == StLoadIfm) && (!ofm_din_valid || ofm_din_ready);
  assign win_full = (row_q >= CntW'(WT_DIM - 1)) && (col_q >= CntW'(WT_DIM - 1));
  assign col_last = (col_q == n_q - CntW'(1));
  assign last_px  = col_last && (row_q == n_q - CntW'(1));
  assign wt_last  = (wt_cnt_q == WtCntW'(KK - 1));

  conv_line_buffer_ys #(
    .DWIDTH    (DWIDTH),
    .WT_DIM    (WT_DIM),
    .MAX_FM_DIM(MAX_FM_DIM)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start && (state == StIdle)),
    .shift  (ifm_fire),
    .row_len(n_q),
    .pix    (ifm_dout),
    .win    (win)
  );

  // Kernel shifts in from the top so wt_q[0] ends up holding the first (top-left) weight.
  always_ff @(posedge clk) begin
    if (wt_fire) begin
      for (int i = 0; i < KK - 1; i++) wt_q[i] <= wt_q[i+1];
      wt_q[KK-1] <= wt_dout;
    end
  end

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < WT_DIM; i++) begin
      for (int j = 0; j < WT_DIM; j++) begin
        prod = $signed(win[i][j]) * $signed(wt_q[i*WT_DIM+j]);
        acc  = acc + AccW'(prod);
      end
    end
`ifdef CONV_RELU_EN
    result = acc[DWIDTH-1] ? '0 : acc[DWIDTH-1:0];
`else
    result = acc[DWIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      wt_dout_ready <= 1'b0;
      ofm_din_valid <= 1'b0;
      ofm_din       <= '0;
      ofm_addr      <= '0;
      n_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      wt_cnt_q      <= '0;
    end else begin
      done <= 1'b0;
      if (ofm_fire) begin
        ofm_din_valid <= 1'b0;
        ofm_addr      <= ofm_addr + 1'b1;
      end
      unique case (state)
        StIdle: if (start) begin
          ofm_addr <= '0;
          row_q    <= '0;
          col_q    <= '0;
          wt_cnt_q <= '0;
          busy     <= 1'b1;
          if (fm_dim > 32'(MAX_FM_DIM)) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state         <= StLoadWt;
            wt_dout_ready <= 1'b1;
            n_q           <= fm_dim[CntW-1:0];
          end
        end
        StLoadWt: if (wt_fire) begin
          wt_cnt_q <= wt_cnt_q + 1'b1;
          if (wt_last) begin
            wt_dout_ready <= 1'b0;
            if (n_q == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StLoadIfm;
            end
          end
        end
        StLoadIfm: if (ifm_fire) begin
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (win_full) begin
            ofm_din_valid <= 1'b1;
            ofm_din       <= result;
          end
          // With N < K nothing is pending, so finish without passing through DRAIN.
          if (last_px) begin
            if (win_full) begin
              state <= StDrain;
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StDrain: if (!ofm_din_valid || ofm_din_ready) begin
          state <= StDone;
          done  <= 1'b1;
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_compute_ys.sv
// Self-checking bench for conv_compute_ys: a reference convolution fills a scoreboard
// that is drained as the DUT emits output pixels.
module tb_conv_compute_ys;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int K      = 3;
  localparam int KK     = K * K;
  localparam int MaxDim = 64;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [31:0]   fm_dim;
  logic [AW-1:0] wt_addr, ifm_addr, ofm_addr;
  logic [DW-1:0] wt_dout, ifm_dout, ofm_din;
  logic          wt_dout_valid, wt_dout_ready, ifm_dout_valid, ifm_dout_ready;
  logic          ofm_din_valid, ofm_din_ready;

  int checks = 0;
  int errors = 0;
  int kern[KK];
  int pix[];
  logic [DW-1:0] exp_data[$];
  int            exp_addr[$];

  conv_compute_ys #(
    .DWIDTH(DW), .AWIDTH(AW), .WT_DIM(K), .MAX_FM_DIM(MaxDim)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fm_dim(fm_dim), .busy(busy), .done(done),
    .wt_addr(wt_addr), .wt_dout(wt_dout), .wt_dout_valid(wt_dout_valid),
    .wt_dout_ready(wt_dout_ready), .ifm_addr(ifm_addr), .ifm_dout(ifm_dout),
    .ifm_dout_valid(ifm_dout_valid), .ifm_dout_ready(ifm_dout_ready),
    .ofm_addr(ofm_addr), .ofm_din(ofm_din), .ofm_din_valid(ofm_din_valid),
    .ofm_din_ready(ofm_din_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_px(int n, int r, int c);
    longint s = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(kern[i*K+j]) * longint'(pix[(r+i)*n + c + j]);
    e = s[DW-1:0];
`ifdef CONV_RELU_EN
    if (e[DW-1]) e = '0;
`endif
    return e;
  endfunction

  task automatic run_job(input int n, input int stall_len, input bit gaps, input int abort_px,
                         output int done_cyc);
    int  wi = 0, pi = 0, cyc = 0, last_evt = 0, exp_n = 0, fires = 0, stall_left = 0;
    bit  done_seen = 0, stalled_once = 0, aborted = 0, oversize;
    logic [DW-1:0] held;
    oversize = (n > MaxDim);
    done_cyc = -1;
    if (!oversize && n >= K)
      for (int r = 0; r <= n - K; r++)
        for (int c = 0; c <= n - K; c++) begin
          exp_data.push_back(model_px(n, r, c));
          exp_addr.push_back(exp_n);
          exp_n++;
        end
    @(negedge clk);
    start = 1'b1; fm_dim = n; wt_dout_valid = 1'b0; ifm_dout_valid = 1'b0; ofm_din_ready = 1'b1;
    while (!done_seen && !aborted && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
      end
      if (done) begin
        checks++;
        done_seen = 1;
        done_cyc  = cyc;
        if (cyc != last_evt + 1) begin
          errors++;
          $display("FAIL done_timing n=%0d got cycle %0d want %0d", n, cyc, last_evt + 1);
        end
      end else begin
        if (!stalled_once && stall_len > 0 && ofm_din_valid) begin
          stalled_once = 1; stall_left = stall_len; held = ofm_din;
        end
        wt_dout_valid  = (wi < KK) && (!gaps || $urandom_range(3) != 0);
        wt_dout        = (wi < KK) ? kern[wi] : '0;
        ifm_dout_valid = (pi < n * n) && (!gaps || $urandom_range(3) != 0);
        ifm_dout       = (pi < n * n) ? pix[pi] : '0;
        ofm_din_ready  = (stall_left == 0);
        #1;
        if (stall_left > 0) begin
          checks++;
          if (ifm_dout_ready !== 1'b0 || ofm_din !== held || ofm_din_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got rdy=%b data=%0h vld=%b want rdy=0 data=%0h vld=1",
                     ifm_dout_ready, ofm_din, ofm_din_valid, held);
          end
          stall_left--;
        end
        if (wt_dout_valid && wt_dout_ready) wi++;
        if (ifm_dout_valid && ifm_dout_ready) begin
          pi++;
          if (exp_n == 0) last_evt = cyc;
        end
        if (ofm_din_valid && ofm_din_ready) begin
          fires++;
          last_evt = cyc;
          checks++;
          if (exp_data.size() == 0) begin
            errors++;
            $display("FAIL ofm_extra got addr=%0d data=%0h want no output", ofm_addr, ofm_din);
          end else begin
            logic [DW-1:0] ed;
            int ea;
            ed = exp_data.pop_front();
            ea = exp_addr.pop_front();
            if (ofm_din !== ed || ofm_addr !== AW'(ea)) begin
              errors++;
              $display("FAIL ofm_pixel got addr=%0d data=%0h want addr=%0d data=%0h",
                       ofm_addr, ofm_din, ea, ed);
            end
          end
        end
        if (abort_px >= 0 && pi == abort_px) aborted = 1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0; wt_dout_valid = 1'b0; ifm_dout_valid = 1'b0;
      #1;
      checks++;
      if ({busy, done, wt_dout_ready, ifm_dout_ready, ofm_din_valid} !== 5'b0 ||
          ofm_din !== '0 || ofm_addr !== '0) begin
        errors++;
        $display("FAIL reset_mid_job got ctl=%b data=%0h addr=%0d want all zero",
                 {busy, done, wt_dout_ready, ifm_dout_ready, ofm_din_valid}, ofm_din, ofm_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_data.delete();
      exp_addr.delete();
      return;
    end
    wt_dout_valid = 1'b0; ifm_dout_valid = 1'b0; ofm_din_ready = 1'b1;
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL done_timeout n=%0d got no done want done", n);
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
      end
    end
    checks++;
    if (fires != exp_n || exp_data.size() != 0) begin
      errors++;
      $display("FAIL ofm_count n=%0d got %0d want %0d", n, fires, exp_n);
    end
    checks++;
    if (wi != (oversize ? 0 : KK) || pi != (oversize ? 0 : n * n)) begin
      errors++;
      $display("FAIL accept_count n=%0d got wt=%0d ifm=%0d want wt=%0d ifm=%0d", n, wi, pi,
               oversize ? 0 : KK, oversize ? 0 : n * n);
    end
    exp_data.delete();
    exp_addr.delete();
  endtask

  task automatic set_centre_kernel();
    for (int i = 0; i < KK; i++) kern[i] = (i == KK / 2) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; fm_dim = '0; wt_dout = '0; ifm_dout = '0;
    wt_dout_valid = 1'b0; ifm_dout_valid = 1'b0; ofm_din_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, wt_dout_ready, ifm_dout_ready, ofm_din_valid} !== 5'b0 ||
        ofm_din !== '0 || ofm_addr !== '0 || wt_addr !== '0 || ifm_addr !== '0) begin
      errors++;
      $display("FAIL reset_values got ctl=%b data=%0h addr=%0d wa=%0d ia=%0d want all zero",
               {busy, done, wt_dout_ready, ifm_dout_ready, ofm_din_valid}, ofm_din, ofm_addr,
               wt_addr, ifm_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_centre();
    int dc;
    set_centre_kernel();
    pix = new[16];
    for (int i = 0; i < 16; i++) pix[i] = i;
    run_job(4, 0, 0, -1, dc);
  endtask

  task automatic test_ones();
    int dc;
    for (int i = 0; i < KK; i++) kern[i] = 1;
    pix = new[9];
    for (int i = 0; i < 9; i++) pix[i] = 2;
    run_job(3, 0, 0, -1, dc);
  endtask

  task automatic test_ramp_stall();
    int dc;
    kern = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    pix = new[36];
    for (int i = 0; i < 36; i++) pix[i] = i;
    run_job(6, 5, 0, -1, dc);
  endtask

  task automatic test_small_and_oversize();
    int dc;
    set_centre_kernel();
    pix = new[4];
    for (int i = 0; i < 4; i++) pix[i] = i + 1;
    run_job(2, 0, 0, -1, dc);
    pix = new[(MaxDim + 1) * (MaxDim + 1)];
    run_job(MaxDim + 1, 0, 0, -1, dc);
  endtask

  task automatic test_negative();
    int dc;
    for (int i = 0; i < KK; i++) kern[i] = -1;
    pix = new[9];
    for (int i = 0; i < 9; i++) pix[i] = 1;
    run_job(3, 0, 0, -1, dc);
  endtask

  task automatic test_random_gaps();
    int dc;
    for (int i = 0; i < KK; i++) kern[i] = int'($urandom);
    pix = new[64];
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom);
    run_job(8, 3, 1, -1, dc);
  endtask

  task automatic test_back_to_back();
    int dc;
    for (int i = 0; i < KK; i++) kern[i] = int'($urandom_range(200)) - 100;
    pix = new[256];
    for (int i = 0; i < 256; i++) pix[i] = int'($urandom_range(2000)) - 1000;
    run_job(16, 0, 0, -1, dc);
    checks++;
    if (dc != KK + 256 + 2) begin
      errors++;
      $display("FAIL throughput got done at cycle %0d want %0d", dc, KK + 256 + 2);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    set_centre_kernel();
    pix = new[16];
    for (int i = 0; i < 16; i++) pix[i] = 100 + i;
    run_job(4, 0, 0, 6, dc);
    test_centre();
  endtask

  initial begin
    test_reset();
    test_centre();
    test_ones();
    test_ramp_stall();
    test_small_and_oversize();
    test_negative();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
